// File: rtl/lms_pkg.sv
// ----------------------------------------------------------------------------
// lms_pkg
// Shared types and defaults for the LMS adaptive-filter sequencer.
//   lms_seq_state_e : sequencer phase encoding
//   LMS_N_TAPS_DEF  : default number of taps per filter
// ----------------------------------------------------------------------------
package lms_pkg;

    localparam int LMS_N_TAPS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILT,
        WUPD,
        SHIFT,
        DONE
    } lms_seq_state_e;

endpackage

// File: rtl/lms_tap_counter.sv
// ----------------------------------------------------------------------------
// lms_tap_counter
// Tap index counter for the FILT and WUPD phases.
//   clk      : clock, rising edge
//   rstn     : asynchronous active-low reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : advance count by one
//   count    : current tap index
//   last_tap : count == N_TAPS-1
// ----------------------------------------------------------------------------
module lms_tap_counter
    import lms_pkg::*;
#(
    parameter int N_TAPS = LMS_N_TAPS_DEF,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last_tap
);

    // NOTE: state flops use non-blocking assignments and the async reset is in
    // the sensitivity list, so reset takes effect without waiting for a clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last_tap = (count == CNT_W'(N_TAPS - 1));

endmodule

// File: rtl/lms_phase_sequencer.sv
// ----------------------------------------------------------------------------
// lms_phase_sequencer
// Central sequencer for the two-channel LMS datapath. For each accepted sample
// it runs FILT (N_TAPS cycles), WUPD (N_TAPS cycles), SHIFT (1 cycle) and DONE
// (1 cycle, out_valid). All datapath enables are decoded from the state
// register; only sample_acc is combinational.
//
// Ports:
//   clk, rstn    : clock (rising edge) / asynchronous active-low reset
//   sample_stb   : new-sample pulse
//   flush        : synchronous abort of the current frame
//   ovr_clr      : clears the sticky overrun flag
//   adapt_freeze : (LMS_SEQ_ADAPT_FREEZE_EN only) skip WUPD for this frame,
//                  sampled on the sample_acc cycle
//   sample_acc   : sample accepted this cycle (loads delay-line head)
//   filt_en      : filter/error phase active
//   wupd_en      : weight-update phase active
//   shift_en     : one-cycle delay-line shift
//   tap_idx      : current tap during FILT/WUPD, else 0
//   out_valid    : filter output complete
//   busy         : state != IDLE
//   overrun      : sticky, a sample arrived while it could not be accepted
//   frame_cnt    : completed frames, wraps
//
// Build option: define LMS_SEQ_ADAPT_FREEZE_EN to add the adapt_freeze input.
// ----------------------------------------------------------------------------
module lms_phase_sequencer
    import lms_pkg::*;
#(
    parameter int N_TAPS = LMS_N_TAPS_DEF,
    parameter int CNT_W  = 5,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sample_stb,
    input  logic              flush,
    input  logic              ovr_clr,
`ifdef LMS_SEQ_ADAPT_FREEZE_EN
    input  logic              adapt_freeze,
`endif
    output logic              sample_acc,
    output logic              filt_en,
    output logic              wupd_en,
    output logic              shift_en,
    output logic [CNT_W-1:0]  tap_idx,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic [FCNT_W-1:0] frame_cnt
);

    lms_seq_state_e state, state_next;
    logic           cnt_clr, cnt_en, last_tap;
    logic           ovr_set;
    logic           freeze;

    lms_tap_counter #(
        .N_TAPS (N_TAPS),
        .CNT_W  (CNT_W)
    ) u_tap_counter (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (tap_idx),
        .last_tap (last_tap)
    );

    assign sample_acc = sample_stb && (state == IDLE || state == DONE);

`ifdef LMS_SEQ_ADAPT_FREEZE_EN
    logic freeze_q;

    // Latched only when a frame really starts, so a flushed accept leaves it alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            freeze_q <= 1'b0;
        end else if (sample_acc && !flush) begin
            freeze_q <= adapt_freeze;
        end
    end

    assign freeze = freeze_q;
`else
    assign freeze = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b1;   // counter idles at 0 outside the tap phases
        cnt_en     = 1'b0;
        ovr_set    = 1'b0;

        case (state)
            IDLE: begin
                if (sample_stb) state_next = FILT;
            end
            FILT: begin
                ovr_set = sample_stb;
                if (last_tap) begin
                    state_next = freeze ? SHIFT : WUPD;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            WUPD: begin
                ovr_set = sample_stb;
                if (last_tap) begin
                    state_next = SHIFT;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            SHIFT: begin
                ovr_set    = sample_stb;
                state_next = DONE;
            end
            DONE: begin
                state_next = sample_stb ? FILT : IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Flush overrides everything; a coincident strobe is silently dropped.
        if (flush) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
            cnt_en     = 1'b0;
            ovr_set    = 1'b0;
        end
    end

    // frame_cnt advances on entry to DONE, so it already shows the new count
    // while out_valid is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
        end else if (state == SHIFT && !flush) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    // A new overrun wins over a simultaneous clear; flush freezes the flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (!flush) begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign filt_en   = (state == FILT);
    assign wupd_en   = (state == WUPD);
    assign shift_en  = (state == SHIFT);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
